// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave keypad front end and controller:
// keypad FSM states, BCD widths and the one-hot key to BCD encoder.
package microwave_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned KEY_W = 10;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX = BCD_W'(5);

  typedef enum logic [1:0] {
    KP_IDLE     = 2'd0,
    KP_DEBOUNCE = 2'd1,
    KP_HELD     = 2'd2
  } kp_state_e;

  function automatic logic is_single_key(input logic [KEY_W-1:0] keys);
    return ($countones(keys) == 1);
  endfunction

  // Index of the set bit; only meaningful for single-hot codes.
  function automatic logic [BCD_W-1:0] onehot_to_bcd(input logic [KEY_W-1:0] keys);
    logic [BCD_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      if (keys[i]) idx = BCD_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Keypad sampler and press/release debouncer producing a one-cycle accept strobe.
// Define KEYPAD_ENTRY_DEBOUNCE_EN to compile in the stability counters.
module keypad_debounce
  import microwave_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             clearn,
  input  logic [KEY_W-1:0] keypad,
  output logic             accept,
  output logic [BCD_W-1:0] code
);

  if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > 255)) begin : g_bad_cfg
    $error("keypad_debounce: DEBOUNCE_CYCLES must be within 1..255");
  end

  logic [KEY_W-1:0] kp_q;
  logic             kp_valid;
  kp_state_e        state_q, state_d;
  logic             accept_d;

  assign kp_valid = is_single_key(kp_q);

`ifdef KEYPAD_ENTRY_DEBOUNCE_EN
  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic [KEY_W-1:0] code_q, code_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       cnt_inc;

  assign cnt_inc = cnt_q + 8'd1;

  // One counter serves both phases: press stability in DEBOUNCE, release
  // stability in HELD. A limit of 1 accepts straight out of IDLE.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    accept_d = 1'b0;
    case (state_q)
      KP_IDLE: begin
        if (kp_valid) begin
          code_d = kp_q;
          if (DB_LIMIT == 8'd1) begin
            accept_d = 1'b1;
            state_d  = KP_HELD;
            cnt_d    = '0;
          end else begin
            state_d = KP_DEBOUNCE;
            cnt_d   = 8'd1;
          end
        end
      end
      KP_DEBOUNCE: begin
        if (kp_q == code_q) begin
          if (cnt_inc == DB_LIMIT) begin
            accept_d = 1'b1;
            state_d  = KP_HELD;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = KP_IDLE;
          cnt_d   = '0;
        end
      end
      KP_HELD: begin
        if (kp_q == '0) begin
          if (cnt_inc == DB_LIMIT) begin
            state_d = KP_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = KP_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    kp_q <= keypad;
    if (!clearn) begin
      state_q <= KP_IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  always_comb begin
    state_d  = state_q;
    accept_d = 1'b0;
    case (state_q)
      KP_IDLE: begin
        if (kp_valid) begin
          accept_d = 1'b1;
          state_d  = KP_HELD;
        end
      end
      KP_HELD: begin
        if (kp_q == '0) state_d = KP_IDLE;
      end
      default: state_d = KP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    kp_q <= keypad;
    if (!clearn) begin
      state_q <= KP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`endif

  // On every accepting edge kp_q holds the accepted code itself.
  assign accept = accept_d;
  assign code   = onehot_to_bcd(kp_q);

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: debounced digit entry shifted into a min/sec-tens/sec-units
// BCD time buffer. Debounce counters are present only with KEYPAD_ENTRY_DEBOUNCE_EN.
module keypad_entry
  import microwave_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [9:0] keypad,
  input  logic       load_en,
  input  logic       clear_buf,
  output logic       digit_valid,
  output logic [3:0] digit,
  output logic [3:0] min_bcd,
  output logic [3:0] sec_tens_bcd,
  output logic [3:0] sec_units_bcd,
  output logic       time_nonzero
);

  logic             accept;
  logic [BCD_W-1:0] code;

  logic             digit_valid_q, digit_valid_d;
  logic [BCD_W-1:0] digit_q, digit_d;
  logic [BCD_W-1:0] min_q, min_d;
  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] units_q, units_d;

  keypad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .clearn (clearn),
    .keypad (keypad),
    .accept (accept),
    .code   (code)
  );

  always_comb begin
    digit_valid_d = accept;
    digit_d       = accept ? code : digit_q;
    min_d         = min_q;
    tens_d        = tens_q;
    units_d       = units_q;
    if (clear_buf) begin
      min_d   = '0;
      tens_d  = '0;
      units_d = '0;
    end else if (accept && load_en) begin
      // Units digit moving into seconds-tens is clamped to keep seconds < 60.
      min_d   = tens_q;
      tens_d  = (units_q > SEC_TENS_MAX) ? SEC_TENS_MAX : units_q;
      units_d = code;
    end
  end

  always_ff @(posedge clk) begin
    if (!clearn) begin
      digit_valid_q <= 1'b0;
      digit_q       <= '0;
      min_q         <= '0;
      tens_q        <= '0;
      units_q       <= '0;
    end else begin
      digit_valid_q <= digit_valid_d;
      digit_q       <= digit_d;
      min_q         <= min_d;
      tens_q        <= tens_d;
      units_q       <= units_d;
    end
  end

  assign digit_valid   = digit_valid_q;
  assign digit         = digit_q;
  assign min_bcd       = min_q;
  assign sec_tens_bcd  = tens_q;
  assign sec_units_bcd = units_q;
  assign time_nonzero  = (min_q != '0) || (tens_q != '0) || (units_q != '0);

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: press/shift/clamp, bounce, multi-hot,
// clear_buf priority, reset while held and load_en gating.
module tb_keypad_entry;

`ifdef KEYPAD_ENTRY_DEBOUNCE_EN
  localparam int LAT           = 4;
  localparam int BOUNCE_PULSES = 1;
  localparam int BOUNCE_FIRST  = 9;
`else
  localparam int LAT           = 1;
  localparam int BOUNCE_PULSES = 3;
  localparam int BOUNCE_FIRST  = 2;
`endif

  logic       clk = 1'b0;
  logic       clearn;
  logic [9:0] keypad;
  logic       load_en;
  logic       clear_buf;
  logic       digit_valid;
  logic [3:0] digit;
  logic [3:0] min_bcd;
  logic [3:0] sec_tens_bcd;
  logic [3:0] sec_units_bcd;
  logic       time_nonzero;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_entry #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .clearn        (clearn),
    .keypad        (keypad),
    .load_en       (load_en),
    .clear_buf     (clear_buf),
    .digit_valid   (digit_valid),
    .digit         (digit),
    .min_bcd       (min_bcd),
    .sec_tens_bcd  (sec_tens_bcd),
    .sec_units_bcd (sec_units_bcd),
    .time_nonzero  (time_nonzero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] buf_val();
    return {20'd0, min_bcd, sec_tens_bcd, sec_units_bcd};
  endfunction

  // Hold key k for 'hold' edges then release for 'rel' edges; expects one
  // pulse at edge 1+LAT (edge 1 samples the key into kp_q).
  task automatic press(input int k, input int hold, input int rel, input string tag);
    int pulses;
    int pulse_at;
    logic [3:0] got_digit;
    pulses    = 0;
    pulse_at  = -1;
    got_digit = 4'hf;
    keypad    = 10'd1 << k;
    for (int i = 1; i <= hold + rel; i++) begin
      if (i == hold + 1) keypad = '0;
      tick();
      if (digit_valid) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
        got_digit = digit;
      end
    end
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_latency"}, pulse_at, 1 + LAT);
    check({tag, "_digit"}, got_digit, k);
  endtask

  initial begin
    int pulses;
    int first_at;

    clearn    = 1'b0;
    keypad    = '0;
    load_en   = 1'b1;
    clear_buf = 1'b0;
    tick();
    tick();
    check("rst_valid", digit_valid, 0);
    check("rst_digit", digit, 0);
    check("rst_buf", buf_val(), 32'h000);
    check("rst_nonzero", time_nonzero, 0);
    clearn = 1'b1;
    tick();

    press(7, 10, 6, "key7");
    check("key7_buf", buf_val(), 32'h007);
    check("key7_nonzero", time_nonzero, 1);

    clear_buf = 1'b1;
    tick();
    clear_buf = 1'b0;
    check("clr_buf", buf_val(), 32'h000);
    check("clr_nonzero", time_nonzero, 0);

    press(1, 6, 6, "key1");
    check("key1_buf", buf_val(), 32'h001);
    press(3, 6, 6, "key3");
    check("key3_buf", buf_val(), 32'h013);
    press(0, 6, 6, "key0");
    check("key0_buf", buf_val(), 32'h130);
    press(9, 6, 6, "key9");
    check("key9_buf", buf_val(), 32'h309);
    check("key9_nonzero", time_nonzero, 1);

    clear_buf = 1'b1;
    tick();
    clear_buf = 1'b0;
    press(8, 6, 6, "key8");
    check("key8_buf", buf_val(), 32'h008);
    press(2, 6, 6, "key2");
    check("clamp_buf", buf_val(), 32'h052);

    // Bounce on key 4 with load_en low: buffer must stay 0/5/2.
    load_en  = 1'b0;
    pulses   = 0;
    first_at = -1;
    for (int n = 1; n <= 22; n++) begin
      keypad = ((n == 1) || (n == 3) || ((n >= 5) && (n <= 14))) ? 10'd1 << 4 : 10'd0;
      tick();
      if (digit_valid) begin
        pulses++;
        if (first_at < 0) first_at = n;
      end
    end
    check("bounce_pulses", pulses, BOUNCE_PULSES);
    check("bounce_first", first_at, BOUNCE_FIRST);
    check("bounce_digit", digit, 4);
    check("noload_buf", buf_val(), 32'h052);

    load_en = 1'b1;
    pulses  = 0;
    keypad  = 10'b0000000011;
    for (int n = 1; n <= 26; n++) begin
      if (n == 21) keypad = '0;
      tick();
      if (digit_valid) pulses++;
    end
    check("multihot_pulses", pulses, 0);
    check("multihot_buf", buf_val(), 32'h052);

    // clear_buf coincident with the accept edge of key 6.
    keypad = 10'd1 << 6;
    for (int n = 1; n <= 1 + LAT; n++) begin
      if (n == 1 + LAT) clear_buf = 1'b1;
      tick();
    end
    clear_buf = 1'b0;
    check("clracc_valid", digit_valid, 1);
    check("clracc_digit", digit, 6);
    check("clracc_buf", buf_val(), 32'h000);
    check("clracc_nonzero", time_nonzero, 0);
    keypad = '0;
    for (int n = 1; n <= 8; n++) tick();

    // Reset for one cycle while key 5 is held in HELD.
    keypad = 10'd1 << 5;
    for (int n = 1; n <= 1 + LAT; n++) tick();
    check("held_valid", digit_valid, 1);
    check("held_buf", buf_val(), 32'h005);
    tick();
    tick();
    clearn = 1'b0;
    tick();
    clearn = 1'b1;
    check("hrst_valid", digit_valid, 0);
    check("hrst_digit", digit, 0);
    check("hrst_buf", buf_val(), 32'h000);
    check("hrst_nonzero", time_nonzero, 0);
    load_en  = 1'b0;
    pulses   = 0;
    first_at = -1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (digit_valid) begin
        pulses++;
        if (first_at < 0) first_at = n;
      end
    end
    check("reacc_pulses", pulses, 1);
    check("reacc_latency", first_at, LAT);
    check("reacc_digit", digit, 5);
    check("reacc_buf", buf_val(), 32'h000);
    keypad = '0;
    for (int n = 1; n <= 8; n++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
